// File: rtl/hex_display_ctrl.sv
// Seven-segment driver for DIGITS hex digits: latched value, leading-zero blanking,
// per-digit blink, and both parallel and time-multiplexed (scanned) outputs.
module hex_display_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     blink,
  output logic [7*DIGITS-1:0]   hex_all,
  output logic [6:0]            seg_mux,
  output logic [DIGITS-1:0]     dig_en
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] r_shadow;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [IDX_W-1:0]    r_dig_idx;
  logic [BLK_W-1:0]    r_blink_cnt;
  logic                r_blink_phase;
  logic [7*DIGITS-1:0] r_hex_all;
  logic [6:0]          r_seg_mux;
  logic [DIGITS-1:0]   r_dig_en;

  logic [DIGITS-1:0]   w_blank;
  logic [7*DIGITS-1:0] w_hex_next;
  logic [6:0]          w_seg_next;
  logic [DIGITS-1:0]   w_dig_en_next;
  logic                w_scan_wrap;
  logic                w_blink_wrap;

  function automatic logic [6:0] seg_pattern(input logic [3:0] n);
    case (n)
      4'h0: seg_pattern = 7'h3F;
      4'h1: seg_pattern = 7'h06;
      4'h2: seg_pattern = 7'h5B;
      4'h3: seg_pattern = 7'h4F;
      4'h4: seg_pattern = 7'h66;
      4'h5: seg_pattern = 7'h6D;
      4'h6: seg_pattern = 7'h7D;
      4'h7: seg_pattern = 7'h07;
      4'h8: seg_pattern = 7'h7F;
      4'h9: seg_pattern = 7'h6F;
      4'hA: seg_pattern = 7'h77;
      4'hB: seg_pattern = 7'h7C;
      4'hC: seg_pattern = 7'h39;
      4'hD: seg_pattern = 7'h5E;
      4'hE: seg_pattern = 7'h79;
      default: seg_pattern = 7'h71;
    endcase
  endfunction

  // Walk from the top digit down so zero_run means "this nibble and all above are 0".
  always_comb begin : decode
    logic zero_run;
    zero_run   = 1'b1;
    w_blank    = '0;
    w_hex_next = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (r_shadow[4*i +: 4] == 4'h0);
      w_blank[i] = ((i > 0) && lz_en && zero_run) || (blink[i] && r_blink_phase);
      w_hex_next[7*i +: 7] = w_blank[i] ? 7'h7F : ~seg_pattern(r_shadow[4*i +: 4]);
    end
  end

  always_comb begin
    w_seg_next = 7'h7F;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_dig_idx == IDX_W'(i)) w_seg_next = w_hex_next[7*i +: 7];
    end
    w_dig_en_next = ~(DIGITS'(1) << r_dig_idx);
  end

  assign w_scan_wrap  = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
  assign w_blink_wrap = (r_blink_cnt == BLK_W'(BLINK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow      <= '0;
      r_div_cnt     <= '0;
      r_dig_idx     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_hex_all     <= '1;
      r_seg_mux     <= 7'h7F;
      r_dig_en      <= '1;
    end else begin
      if (load) r_shadow <= value;

      if (w_scan_wrap) begin
        r_div_cnt <= '0;
        r_dig_idx <= (r_dig_idx == IDX_W'(DIGITS - 1)) ? '0 : r_dig_idx + IDX_W'(1);
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end

      if (w_blink_wrap) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end

      // seg_mux and dig_en share one edge so a digit never shows a neighbour's segments.
      r_hex_all <= w_hex_next;
      r_seg_mux <= w_seg_next;
      r_dig_en  <= w_dig_en_next;
    end
  end

  assign hex_all = r_hex_all;
  assign seg_mux = r_seg_mux;
  assign dig_en  = r_dig_en;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with DIGITS=4, SCAN_DIV=3, BLINK_DIV=4.
module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        lz_en;
  logic [3:0]  blink;
  logic [27:0] hex_all;
  logic [6:0]  seg_mux;
  logic [3:0]  dig_en;

  int n_vec = 0;
  int n_err = 0;

  int          cyc = 0;
  int          m_idx = 0;
  logic        m_ph = 1'b0;
  logic [15:0] m_shadow = '0;
  logic [27:0] m_hex = '1;

  hex_display_ctrl #(.DIGITS(4), .SCAN_DIV(3), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .lz_en(lz_en),
    .blink(blink), .hex_all(hex_all), .seg_mux(seg_mux), .dig_en(dig_en)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F; 4'h1: seg7 = 7'h06; 4'h2: seg7 = 7'h5B; 4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66; 4'h5: seg7 = 7'h6D; 4'h6: seg7 = 7'h7D; 4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F; 4'h9: seg7 = 7'h6F; 4'hA: seg7 = 7'h77; 4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39; 4'hD: seg7 = 7'h5E; 4'hE: seg7 = 7'h79; default: seg7 = 7'h71;
    endcase
  endfunction

  function automatic logic [27:0] model(input logic [15:0] sh, input logic lz,
                                        input logic [3:0] bl, input logic ph);
    logic [27:0] r;
    logic        upper_zero;
    logic        bk;
    r = '0;
    upper_zero = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (sh[4*i +: 4] != 4'h0) upper_zero = 1'b0;
      bk = ((i > 0) && lz && upper_zero) || (bl[i] && ph);
      r[7*i +: 7] = bk ? 7'h7F : ~seg7(sh[4*i +: 4]);
    end
    return r;
  endfunction

  // One clock: the output after edge k (k = cycles since release) reflects the
  // pre-edge scan index ((k-1)/3)%4 and pre-edge blink phase ((k-1)/4)%2.
  task automatic tick();
    logic        l;
    logic [15:0] v;
    logic        lz;
    logic [3:0]  bl;
    l = load; v = value; lz = lz_en; bl = blink;
    @(posedge clk);
    if (rst_n) begin
      cyc++;
      m_idx = ((cyc - 1) / 3) % 4;
      m_ph  = (((cyc - 1) / 4) % 2) == 1;
      m_hex = model(m_shadow, lz, bl, m_ph);
      if (l) m_shadow = v;
    end
    #1;
  endtask

  task automatic check_scan_cycle(input string tag);
    logic [3:0] one;
    logic [3:0] exp_en;
    one = 4'b0001;
    exp_en = ~(one << m_idx);
    n_vec++;
    if (dig_en !== exp_en) begin
      n_err++;
      $display("FAIL %s dig_en cyc=%0d got %h expected %h", tag, cyc, dig_en, exp_en);
    end
    n_vec++;
    if (seg_mux !== m_hex[7*m_idx +: 7]) begin
      n_err++;
      $display("FAIL %s seg_mux cyc=%0d got %h expected %h", tag, cyc, seg_mux, m_hex[7*m_idx +: 7]);
    end
    n_vec++;
    if (hex_all !== m_hex) begin
      n_err++;
      $display("FAIL %s hex_all cyc=%0d got %h expected %h", tag, cyc, hex_all, m_hex);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (hex_all !== 28'hFFFFFFF) begin n_err++; $display("FAIL reset_hex got %h expected %h", hex_all, 28'hFFFFFFF); end
    n_vec++;
    if (seg_mux !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %h expected 7f", seg_mux); end
    n_vec++;
    if (dig_en !== 4'hF) begin n_err++; $display("FAIL reset_en got %h expected f", dig_en); end
    rst_n = 1'b1;
    cyc = 0; m_shadow = '0;
    tick();
    n_vec++;
    if (hex_all !== {4{7'h40}}) begin n_err++; $display("FAIL release_hex got %h expected %h", hex_all, {4{7'h40}}); end
    n_vec++;
    if (dig_en !== 4'hE) begin n_err++; $display("FAIL release_en got %h expected e", dig_en); end
    n_vec++;
    if (seg_mux !== 7'h40) begin n_err++; $display("FAIL release_seg got %h expected 40", seg_mux); end
  endtask

  task automatic test_load();
    value = 16'h12AF; load = 1'b1;
    tick();
    load = 1'b0;
    n_vec++;
    if (hex_all !== {4{7'h40}}) begin n_err++; $display("FAIL load_latency got %h expected %h", hex_all, {4{7'h40}}); end
    tick();
    n_vec++;
    if (hex_all !== {7'h79, 7'h24, 7'h08, 7'h0E}) begin
      n_err++; $display("FAIL load_12AF got %h expected %h", hex_all, {7'h79, 7'h24, 7'h08, 7'h0E});
    end
    value = 16'hFFFF;
    tick(); tick();
    n_vec++;
    if (hex_all !== {7'h79, 7'h24, 7'h08, 7'h0E}) begin
      n_err++; $display("FAIL no_load_hold got %h expected %h", hex_all, {7'h79, 7'h24, 7'h08, 7'h0E});
    end
  endtask

  task automatic test_lz();
    lz_en = 1'b1; value = 16'h0030; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    n_vec++;
    if (hex_all !== {7'h7F, 7'h7F, 7'h30, 7'h40}) begin
      n_err++; $display("FAIL lz_0030 got %h expected %h", hex_all, {7'h7F, 7'h7F, 7'h30, 7'h40});
    end
    lz_en = 1'b0;
    tick();
    n_vec++;
    if (hex_all !== {7'h40, 7'h40, 7'h30, 7'h40}) begin
      n_err++; $display("FAIL lz_off got %h expected %h", hex_all, {7'h40, 7'h40, 7'h30, 7'h40});
    end
    lz_en = 1'b1; value = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    n_vec++;
    if (hex_all !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
      n_err++; $display("FAIL lz_0000 got %h expected %h", hex_all, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    end
    lz_en = 1'b0;
  endtask

  task automatic test_scan();
    value = 16'h12AF; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    for (int k = 0; k < 24; k++) begin
      tick();
      check_scan_cycle("scan");
    end
  endtask

  task automatic test_blink();
    logic [6:0] d1;
    blink = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      tick();
      d1 = m_ph ? 7'h7F : 7'h08;
      n_vec++;
      if (hex_all !== {7'h79, 7'h24, d1, 7'h0E}) begin
        n_err++; $display("FAIL blink cyc=%0d got %h expected %h", cyc, hex_all, {7'h79, 7'h24, d1, 7'h0E});
      end
      check_scan_cycle("blink");
    end
    blink = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [8];
    vals = '{16'h0001, 16'h0020, 16'h0300, 16'h4000, 16'hBCDE, 16'h5678, 16'h9000, 16'h0000};
    blink = 4'b0001;
    lz_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      value = vals[k]; load = 1'b1;
      tick();
      check_scan_cycle("b2b");
    end
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_scan_cycle("b2b_tail");
    end
    blink = 4'b0000;
    lz_en = 1'b0;
    value = 16'hC3D4; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int guard;
    guard = 0;
    while (((cyc / 3) % 4) != 2 && guard < 12) begin
      tick();
      guard++;
    end
    n_vec++;
    if (((cyc / 3) % 4) != 2) begin
      n_err++; $display("FAIL midscan_reach got idx %0d expected 2", (cyc / 3) % 4);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (hex_all !== 28'hFFFFFFF) begin n_err++; $display("FAIL midrst_hex got %h expected %h", hex_all, 28'hFFFFFFF); end
    n_vec++;
    if (seg_mux !== 7'h7F) begin n_err++; $display("FAIL midrst_seg got %h expected 7f", seg_mux); end
    n_vec++;
    if (dig_en !== 4'hF) begin n_err++; $display("FAIL midrst_en got %h expected f", dig_en); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc = 0; m_shadow = '0;
    tick();
    n_vec++;
    if (hex_all !== {4{7'h40}}) begin n_err++; $display("FAIL restart_hex got %h expected %h", hex_all, {4{7'h40}}); end
    n_vec++;
    if (dig_en !== 4'hE) begin n_err++; $display("FAIL restart_en got %h expected e", dig_en); end
    for (int k = 0; k < 8; k++) begin
      tick();
      check_scan_cycle("restart");
    end
  endtask

  initial begin
    rst_n = 1'b0; value = '0; load = 1'b0; lz_en = 1'b0; blink = '0;
    test_reset();
    test_load();
    test_lz();
    test_scan();
    test_blink();
    test_back_to_back();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
